// File: rtl/nv_demux2_pipe.sv
// nv_demux2_pipe: pipelined 1:2 valid/ready demux with per-output saturating transfer counters.
// Define NV_DEMUX2_SKID_EN for 2-entry skid stages whose ready is a pure flop output.
module nv_demux2_pipe #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 16
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    input  logic          in_pvld,
    output logic          in_prdy,
    input  logic          in_sel,
    input  logic [DW-1:0] in_pd,
    output logic          out0_pvld,
    input  logic          out0_prdy,
    output logic [DW-1:0] out0_pd,
    output logic          out1_pvld,
    input  logic          out1_prdy,
    output logic [DW-1:0] out1_pd,
    input  logic          cnt_clr,
    output logic [CW-1:0] out0_cnt,
    output logic [CW-1:0] out1_cnt
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic [1:0]    out_rdy;
    logic [1:0]    vld;
    logic [1:0]    accept;
    logic [1:0]    fire;
    logic [DW-1:0] pd [2];
    logic [CW-1:0] cnt [2];

    assign out_rdy = {out1_prdy, out0_prdy};

    // Only the selected stage gates the input; fire is forced low whenever in_pvld is low.
    assign in_prdy = in_sel ? accept[1] : accept[0];
    assign fire[0] = in_pvld & in_prdy & ~in_sel;
    assign fire[1] = in_pvld & in_prdy & in_sel;

`ifdef NV_DEMUX2_SKID_EN
    logic [1:0]    skid_vld;
    logic [DW-1:0] skid_pd [2];

    assign accept = ~skid_vld;

    // A beat arriving while main is held parks in skid; skid refills main on the next drain.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            vld      <= '0;
            skid_vld <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (fire[k]) begin
                    if (vld[k] && !out_rdy[k]) skid_vld[k] <= 1'b1;
                    else                       vld[k]      <= 1'b1;
                end else if (out_rdy[k]) begin
                    if (skid_vld[k]) skid_vld[k] <= 1'b0;
                    else             vld[k]      <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        for (int k = 0; k < 2; k++) begin
            if (fire[k]) begin
                if (vld[k] && !out_rdy[k]) skid_pd[k] <= in_pd;
                else                       pd[k]      <= in_pd;
            end else if (out_rdy[k] && skid_vld[k]) begin
                pd[k] <= skid_pd[k];
            end
        end
    end
`else
    assign accept = ~vld | out_rdy;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            vld <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (fire[k])         vld[k] <= 1'b1;
                else if (out_rdy[k]) vld[k] <= 1'b0;
            end
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        for (int k = 0; k < 2; k++) begin
            if (fire[k]) pd[k] <= in_pd;
        end
    end
`endif

    // Saturating completed-transfer counters; clear beats a same-cycle increment.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (cnt_clr)
                    cnt[k] <= '0;
                else if (vld[k] && out_rdy[k] && cnt[k] != CNT_MAX)
                    cnt[k] <= cnt[k] + CW'(1);
            end
        end
    end

    assign out0_pvld = vld[0];
    assign out1_pvld = vld[1];
    assign out0_pd   = pd[0];
    assign out1_pd   = pd[1];
    assign out0_cnt  = cnt[0];
    assign out1_cnt  = cnt[1];

endmodule

// File: tb/tb_nv_demux2_pipe.sv
// Scoreboard bench for nv_demux2_pipe (CW=4); honours NV_DEMUX2_SKID_EN for ready expectations.
module tb_nv_demux2_pipe;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;
`ifdef NV_DEMUX2_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_pvld = 1'b0;
    logic          in_prdy;
    logic          in_sel = 1'b0;
    logic [DW-1:0] in_pd = '0;
    logic          out0_pvld;
    logic          out0_prdy = 1'b0;
    logic [DW-1:0] out0_pd;
    logic          out1_pvld;
    logic          out1_prdy = 1'b0;
    logic [DW-1:0] out1_pd;
    logic          cnt_clr = 1'b0;
    logic [CW-1:0] out0_cnt;
    logic [CW-1:0] out1_cnt;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int unsigned   m_cnt0 = 0;
    int unsigned   m_cnt1 = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    always #5 clk = ~clk;

    nv_demux2_pipe #(.DW(DW), .CW(CW)) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .in_pvld(in_pvld),
        .in_prdy(in_prdy),
        .in_sel(in_sel),
        .in_pd(in_pd),
        .out0_pvld(out0_pvld),
        .out0_prdy(out0_prdy),
        .out0_pd(out0_pd),
        .out1_pvld(out1_pvld),
        .out1_prdy(out1_prdy),
        .out1_pd(out1_pd),
        .cnt_clr(cnt_clr),
        .out0_cnt(out0_cnt),
        .out1_cnt(out1_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // One clock: drive at negedge, check outputs against the scoreboard, then advance the model.
    task automatic cycle(input logic v, input logic sel, input logic [DW-1:0] pd,
                         input logic r0, input logic r1, input logic clr, input logic r);
        bit acc0, acc1, acc, f0, f1;
        @(negedge clk);
        rst       = r;
        in_pvld   = v;
        in_sel    = v ? sel : 1'($urandom);
        in_pd     = v ? pd : DW'($urandom);
        out0_prdy = r0;
        out1_prdy = r1;
        cnt_clr   = clr;
        #1;
        check("out0_pvld", 64'(out0_pvld), 64'(q0.size() != 0));
        check("out1_pvld", 64'(out1_pvld), 64'(q1.size() != 0));
        if (q0.size() != 0) check("out0_pd", 64'(out0_pd), 64'(q0[0]));
        if (q1.size() != 0) check("out1_pd", 64'(out1_pd), 64'(q1[0]));
        check("out0_cnt", 64'(out0_cnt), 64'(m_cnt0));
        check("out1_cnt", 64'(out1_cnt), 64'(m_cnt1));
        acc0 = SKID ? (q0.size() < 2) : (q0.size() == 0 || r0);
        acc1 = SKID ? (q1.size() < 2) : (q1.size() == 0 || r1);
        acc  = in_sel ? acc1 : acc0;
        check("in_prdy", 64'(in_prdy), 64'(acc));
        if (r) begin
            q0.delete();
            q1.delete();
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            f0 = (q0.size() != 0) && r0;
            f1 = (q1.size() != 0) && r1;
            if (f0) void'(q0.pop_front());
            if (f1) void'(q1.pop_front());
            if (v && acc) begin
                if (in_sel) q1.push_back(pd);
                else        q0.push_back(pd);
            end
            if (clr) begin
                m_cnt0 = 0;
                m_cnt1 = 0;
            end else begin
                if (f0 && m_cnt0 < CMAX) m_cnt0++;
                if (f1 && m_cnt1 < CMAX) m_cnt1++;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n, input logic r0, input logic r1);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, r0, r1, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_prdy", 64'(in_prdy), 64'd1);
        check("rst_out0_pvld", 64'(out0_pvld), 64'd0);
        check("rst_out1_pvld", 64'(out1_pvld), 64'd0);
        check("rst_out0_cnt", 64'(out0_cnt), 64'd0);
        check("rst_out1_cnt", 64'(out1_cnt), 64'd0);

        // Four beats to out0
        cycle(1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h22, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h33, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h44, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b1);
        #2;
        check("t1_out0_cnt", 64'(out0_cnt), 64'd4);
        check("t1_out1_cnt", 64'(out1_cnt), 64'd0);

        // Alternating destinations at full rate
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'(i % 2), 32'hA0 + 32'(i), 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b1);

        // Blocked out0 must not block out1
        cycle(1'b1, 1'b0, 32'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'hAB, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'h66, 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        check("blk_in_prdy", 64'(in_prdy), 64'd0);
        cycle(1'b1, 1'b0, 32'h77, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(4, 1'b1, 1'b1);

        // Stall out1 with data pending
        cycle(1'b1, 1'b1, 32'hC1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'hC2, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            #2;
            check("stall_out1_pd", 64'(out1_pd), 64'h0000_00C1);
            check("stall_out1_pvld", 64'(out1_pvld), 64'd1);
        end
        idle(3, 1'b1, 1'b1);

        // Counter saturation and clear priority
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 1'b0, 32'h1000 + 32'(i), 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        check("sat_out0_cnt", 64'(out0_cnt), 64'd15);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        check("clr_out0_cnt", 64'(out0_cnt), 64'd0);
        check("clr_out1_cnt", 64'(out1_cnt), 64'd0);
        idle(1, 1'b1, 1'b1);

        // Reset with both stages full
        cycle(1'b1, 1'b0, 32'hD0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'hD1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        check("mrst_out0_pvld", 64'(out0_pvld), 64'd0);
        check("mrst_out1_pvld", 64'(out1_pvld), 64'd0);
        check("mrst_in_prdy", 64'(in_prdy), 64'd1);
        check("mrst_out0_cnt", 64'(out0_cnt), 64'd0);
        check("mrst_out1_cnt", 64'(out1_cnt), 64'd0);
        cycle(1'b1, 1'b1, 32'hE1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 32'hE0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
